// File: rtl/sram_mem_ctrl_pkg.sv
// rtl/sram_mem_ctrl_pkg.sv - shared types and constants for the memory-stage SRAM controller
package mips_mem_pkg;
    localparam int CPU_DW   = 16;
    localparam int CPU_AW   = 16;
    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_e;
endpackage

// File: rtl/sram_mem_ctrl_if.sv
// rtl/sram_mem_ctrl_if.sv - pipeline-side command/response bundle of the SRAM controller
interface sram_mem_ctrl_if;
    logic                            req;
    logic                            store;
    logic [mips_mem_pkg::CPU_AW-1:0] addr;
    logic [mips_mem_pkg::CPU_DW-1:0] wdata;
    logic [mips_mem_pkg::CPU_DW-1:0] rdata;
    logic                            sram_busy;
    logic                            done;

    modport master (output req, store, addr, wdata, input rdata, sram_busy, done);
    modport slave  (input req, store, addr, wdata, output rdata, sram_busy, done);
endinterface

// File: rtl/sram_dq_buf.sv
// rtl/sram_dq_buf.sv - tristate driver for the bidirectional SRAM data bus
module sram_dq_buf (
    input  logic        oe,
    input  logic [15:0] dout,
    output logic [15:0] din,
    inout  wire  [15:0] dq
);
    assign dq  = oe ? dout : 16'hzzzz;
    assign din = dq;
endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - sequences EX/MEM loads/stores onto an async 16-bit SRAM; optional SRAM_MEM_CTRL_STATS_EN adds rd/wr counters
module sram_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_ctrl_if.slave     cpu,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
`ifdef SRAM_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]        rd_count,
    output logic [15:0]        wr_count
`endif
);
    if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait_cycles
        $error("sram_mem_ctrl: WAIT_CYCLES=%0d outside legal range 1..15", WAIT_CYCLES);
    end

    mem_state_e        state;
    logic [3:0]        wait_cnt;
    logic              store_q;
    logic [CPU_DW-1:0] wdata_q;
    logic              dq_oe;
    logic [CPU_DW-1:0] dq_in;

    sram_dq_buf u_dq_buf (
        .oe   (dq_oe),
        .dout (wdata_q),
        .din  (dq_in),
        .dq   (sram_dq)
    );

    // Stall must rise in the very cycle the command appears, so IDLE passes req through.
    assign cpu.sram_busy = (state == IDLE) ? cpu.req : (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            store_q   <= 1'b0;
            wdata_q   <= '0;
            dq_oe     <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            cpu.rdata <= '0;
            cpu.done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cpu.done <= 1'b0;
                    dq_oe    <= 1'b0;
                    // req lasts only one cycle upstream, so everything is latched here.
                    if (cpu.req) begin
                        store_q   <= cpu.store;
                        wdata_q   <= cpu.wdata;
                        sram_addr <= SRAM_AW'(cpu.addr);
                        wait_cnt  <= 4'(WAIT_CYCLES - 1);
                        sram_ce_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                        sram_oe_n <= cpu.store;
                        sram_we_n <= ~cpu.store;
                        dq_oe     <= cpu.store;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!store_q) cpu.rdata <= dq_in;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        cpu.done  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Address and write data were held through this cycle for SRAM hold time.
                    cpu.done <= 1'b0;
                    dq_oe    <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_MEM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == DONE) begin
            if (store_q) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - randomized self-checking bench for sram_mem_ctrl against a reference memory model
module tb_sram_mem_ctrl;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    sram_mem_ctrl_if cpu ();
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    sram_mem_ctrl_if cpu1 ();
    wire  [15:0] dq1;
    logic [17:0] addr1;
    logic        ce1, oe1, we1, ub1, lb1;

`ifdef SRAM_MEM_CTRL_STATS_EN
    logic [15:0] rd_count, wr_count, rd_count1, wr_count1;
`endif

    sram_mem_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .cpu(cpu), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
`ifdef SRAM_MEM_CTRL_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    sram_mem_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .cpu(cpu1), .sram_addr(addr1), .sram_dq(dq1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1)
`ifdef SRAM_MEM_CTRL_STATS_EN
        , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
    );

    // Async SRAM model: reads combinational, writes sampled while we_n is low.
    logic [15:0] mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr, pl_data;
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[15:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!ce_n && !we_n) mem[sram_addr[15:0]] <= sram_dq;
    end
    assign dq1 = (!ce1 && !oe1 && we1) ? ~addr1[15:0] : 16'hzzzz;

    logic [15:0] ref_mem [int];
    logic [15:0] addrs [$];
    logic [15:0] exp_rdata;

    int          r_busy, r_oe, r_we, r_done_at;
    logic [15:0] r_dq_done;
    logic [17:0] r_addr_done;
    logic        r_stable;

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[int'(a)] = d;
    endtask

    // Issues one command for a single cycle and observes the access until done.
    task automatic do_access(input logic st, input logic [15:0] a, input logic [15:0] d);
        r_busy = 0; r_oe = 0; r_we = 0; r_done_at = -1; r_stable = 1'b1;
        r_dq_done = '0; r_addr_done = '0;
        cpu.req = 1'b1; cpu.store = st; cpu.addr = a; cpu.wdata = d;
        for (int k = 0; k < 40 && r_done_at < 0; k++) begin
            @(negedge clk);
            if (cpu.sram_busy) r_busy++;
            if (!oe_n) r_oe++;
            if (!we_n) begin
                r_we++;
                if (sram_dq !== d || sram_addr !== {2'b00, a}) r_stable = 1'b0;
            end
            if (cpu.done) begin
                r_done_at = k; r_dq_done = sram_dq; r_addr_done = sram_addr;
            end
            @(posedge clk); #1;
            cpu.req = 1'b0; cpu.store = 1'($urandom);
            cpu.addr = 16'($urandom); cpu.wdata = 16'($urandom);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cpu.req = 1'b0; cpu.store = 1'b0; cpu.addr = '0; cpu.wdata = '0;
        cpu1.req = 1'b0; cpu1.store = 1'b0; cpu1.addr = '0; cpu1.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cpu.rdata !== 16'h0 || cpu.done !== 1'b0 || cpu.sram_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: rdata=%h done=%b busy=%b expected 0/0/0", cpu.rdata, cpu.done, cpu.sram_busy); end
        n_checks++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || sram_addr !== 18'h0) begin
            n_fail++; $display("FAIL reset_strobes: strobes=%b addr=%h expected 11111/0", {ce_n, oe_n, we_n, ub_n, lb_n}, sram_addr); end
        n_checks++; if (dut.u_dq_buf.oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_dq_released: drive=%b expected 0", dut.u_dq_buf.oe); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read;
        preload(16'h0042, 16'hBEEF);
        do_access(1'b0, 16'h0042, 16'h0000);
        exp_rdata = 16'hBEEF;
        n_checks++; if (r_busy !== W + 1) begin n_fail++; $display("FAIL read_busy_cycles: got %0d expected %0d", r_busy, W + 1); end
        n_checks++; if (r_oe !== W || r_we !== 0) begin n_fail++; $display("FAIL read_strobes: oe=%0d we=%0d expected %0d/0", r_oe, r_we, W); end
        n_checks++; if (r_done_at !== W + 1) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", r_done_at, W + 1); end
        n_checks++; if (cpu.rdata !== exp_rdata || cpu.done !== 1'b0) begin
            n_fail++; $display("FAIL read_data: rdata=%h done=%b expected %h/0", cpu.rdata, cpu.done, exp_rdata); end
    endtask

    task automatic test_write;
        do_access(1'b1, 16'h1234, 16'hA5A5);
        ref_mem[int'(16'h1234)] = 16'hA5A5;
        n_checks++; if (r_we !== W || r_oe !== 0) begin n_fail++; $display("FAIL write_strobes: we=%0d oe=%0d expected %0d/0", r_we, r_oe, W); end
        n_checks++; if (!r_stable || r_dq_done !== 16'hA5A5 || r_addr_done !== 18'h01234) begin
            n_fail++; $display("FAIL write_hold: stable=%b dq=%h addr=%h expected 1/a5a5/01234", r_stable, r_dq_done, r_addr_done); end
        n_checks++; if (r_done_at !== W + 1 || cpu.rdata !== exp_rdata) begin
            n_fail++; $display("FAIL write_done_rdata: done_at=%0d rdata=%h expected %0d/%h", r_done_at, cpu.rdata, W + 1, exp_rdata); end
        n_checks++; if (dut.u_dq_buf.oe !== 1'b0) begin n_fail++; $display("FAIL write_release: drive=%b expected 0", dut.u_dq_buf.oe); end
        do_access(1'b0, 16'h1234, 16'h0000);
        exp_rdata = ref_mem[int'(16'h1234)];
        n_checks++; if (cpu.rdata !== exp_rdata) begin n_fail++; $display("FAIL write_readback: got %h expected %h", cpu.rdata, exp_rdata); end
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 16'h0010, 16'h0001);
        ref_mem[int'(16'h0010)] = 16'h0001;
        n_checks++; if (r_done_at !== W + 1) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", r_done_at, W + 1); end
        do_access(1'b0, 16'h0010, 16'h0000);
        exp_rdata = ref_mem[int'(16'h0010)];
        n_checks++; if (r_done_at !== W + 1 || r_busy !== W + 1) begin
            n_fail++; $display("FAIL b2b_second_latency: done_at=%0d busy=%0d expected %0d/%0d", r_done_at, r_busy, W + 1, W + 1); end
        n_checks++; if (cpu.rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata: got %h expected %h", cpu.rdata, exp_rdata); end
    endtask

    task automatic test_random;
        logic [15:0] a, d;
        for (int i = 0; i < 24; i++) begin
            if (addrs.size() == 0 || $urandom_range(1, 0) == 1) begin
                a = 16'($urandom); d = 16'($urandom);
                do_access(1'b1, a, d);
                ref_mem[int'(a)] = d; addrs.push_back(a);
            end else begin
                a = addrs[$urandom_range(addrs.size() - 1, 0)];
                do_access(1'b0, a, 16'h0000);
                exp_rdata = ref_mem[int'(a)];
            end
            n_checks++; if (r_done_at !== W + 1 || r_busy !== W + 1) begin
                n_fail++; $display("FAIL rand_timing[%0d]: done_at=%0d busy=%0d expected %0d", i, r_done_at, r_busy, W + 1); end
            n_checks++; if (cpu.rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, cpu.rdata, exp_rdata); end
        end
    endtask

    task automatic test_reset_mid_access;
        cpu.req = 1'b1; cpu.store = 1'b1; cpu.addr = 16'h7777; cpu.wdata = 16'h5555;
        @(posedge clk); #1;
        cpu.req = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (we_n !== 1'b0) begin n_fail++; $display("FAIL mid_precondition_we: got %b expected 0", we_n); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[int'(16'h7777)] = 16'h5555;
        exp_rdata = 16'h0000;
        n_checks++; if (we_n !== 1'b1 || ce_n !== 1'b1 || dut.u_dq_buf.oe !== 1'b0 || cpu.sram_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: we_n=%b ce_n=%b drive=%b busy=%b expected 1/1/0/0", we_n, ce_n, dut.u_dq_buf.oe, cpu.sram_busy); end
        n_checks++; if (cpu.rdata !== exp_rdata) begin n_fail++; $display("FAIL mid_rdata: got %h expected %h", cpu.rdata, exp_rdata); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (cpu.done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done[%0d]: got %b expected 0", k, cpu.done); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait1;
        int busy = 0;
        int done_at = -1;
        cpu1.req = 1'b1; cpu1.addr = 16'h00F0;
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            @(negedge clk);
            if (cpu1.sram_busy) busy++;
            if (cpu1.done) done_at = k;
            @(posedge clk); #1;
            cpu1.req = 1'b0; cpu1.addr = 16'($urandom);
        end
        n_checks++; if (busy !== 2 || done_at !== 2) begin
            n_fail++; $display("FAIL wait1_timing: busy=%0d done_at=%0d expected 2/2", busy, done_at); end
        n_checks++; if (cpu1.rdata !== 16'hFF0F) begin n_fail++; $display("FAIL wait1_rdata: got %h expected ff0f", cpu1.rdata); end
    endtask

`ifdef SRAM_MEM_CTRL_STATS_EN
    task automatic test_stats;
        for (int i = 0; i < 3; i++) do_access(1'b0, addrs[i % addrs.size()], 16'h0);
        for (int i = 0; i < 2; i++) do_access(1'b1, 16'h0100 + 16'(i), 16'($urandom));
        n_checks++; if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
            n_fail++; $display("FAIL stats_counts: rd=%0d wr=%0d expected 3/2", rd_count, wr_count); end
        force dut.rd_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.rd_count;
        do_access(1'b0, addrs[0], 16'h0);
        n_checks++; if (rd_count !== 16'hFFFF || wr_count !== 16'd2) begin
            n_fail++; $display("FAIL stats_saturate: rd=%h wr=%0d expected ffff/2", rd_count, wr_count); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_wait1();
`ifdef SRAM_MEM_CTRL_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage controller that sequences every load/store from the EX/MEM pipeline register onto an external asynchronous 16-bit SRAM.
- Generates the `sram_busy` stall that freezes the EX/MEM register and upstream stages while an access is in flight.
- Returns load data to the MEM/WB path.
- One access outstanding at a time; word-addressed.

Parameters:
- WAIT_CYCLES, 2, SRAM access cycles per transaction (legal range 1..15).
- SRAM_AW, 18, external SRAM address width; CPU address is zero-extended.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  1  memory command present (EX/MEM is_mem_cmd_out)
- store  in  1  1 = write, 0 = read (EX/MEM mem_stroe_out)
- addr  in  16  word address (EX/MEM res_out)
- wdata  in  16  store data (EX/MEM store_data_out)
- rdata  out  16  load data, registered
- sram_busy  out  1  stall to pipeline
- done  out  1  one-cycle pulse, access complete
- sram_addr  out  SRAM_AW  SRAM address
- sram_dq  inout  16  SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes

Behaviour:
- Reset is synchronous and active-high, on clk rising edge. It forces:
  - state IDLE
  - rdata=0, done=0, sram_busy=0
  - sram_ce_n=oe_n=we_n=1, ub_n=lb_n=1
  - sram_dq hi-Z, sram_addr=0, wait counter=0
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - sram_busy = req (combinational), so the pipeline stalls in the same cycle the command appears.
  - On the edge with req=1: latch store/addr/wdata into internal registers, load wait counter with WAIT_CYCLES-1, go to ACCESS.
  - The latch is mandatory. The EX/MEM register clears is_mem_cmd after the first stalled edge, so req is only guaranteed for one cycle.
- ACCESS:
  - sram_busy=1; ce_n=0, ub_n=lb_n=0; sram_addr = zero-extended latched addr.
  - Read: oe_n=0, we_n=1, dq hi-Z.
  - Write: oe_n=1, we_n=0, dq driven with latched wdata.
  - Counter decrements each cycle. When the counter is 0, at that edge:
    - read: capture sram_dq into rdata;
    - then go to DONE.
- DONE:
  - sram_busy=0, done=1 for exactly one cycle; the pipeline advances on this edge.
  - ce_n/oe_n/we_n=1; address and write data remain driven this cycle (hold time); dq released at the end of DONE.
  - Unconditional return to IDLE. req in DONE is ignored, because upstream guarantees it is 0 here.
- Latency: a request seen in IDLE at cycle t gives done at cycle t+WAIT_CYCLES+1. Stall length is WAIT_CYCLES+1 cycles.
- rdata holds its value until the next completed read; writes never change it.
- Back-to-back memory instructions: the second req appears in IDLE the cycle after DONE, with no bubble beyond the state transition.
- Reset mid-ACCESS:
  - abort immediately: strobes deassert and dq goes hi-Z at that edge;
  - rdata is cleared and no done pulse occurs.
- WAIT_CYCLES=1: ACCESS lasts one cycle.
- Out-of-range WAIT_CYCLES is a parameter error; flag it in elaboration.

Optional Feature:
- Macro: SRAM_MEM_CTRL_STATS_EN.
- When defined:
  - adds outputs rd_count[15:0] and wr_count[15:0];
  - each counter increments on the DONE cycle of a read or write respectively;
  - counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - CPU data width constant 16 and address width constant 16;
  - the WAIT_CYCLES legal-range constants.
- One sub-module is natural: sram_dq_buf, the tristate driver for sram_dq (drive-enable, out data, in data). It isolates inout handling for synthesis and simulation.

Test Plan:
- Read, WAIT_CYCLES=2: SRAM model holds 0xBEEF at 0x0042; req=1, store=0, addr=0x0042 for one cycle → sram_busy high 3 cycles; oe_n low 2 cycles; done pulse at t+3; rdata=0xBEEF.
- Write: req, store=1, addr=0x1234, wdata=0xA5A5 → we_n low 2 cycles; dq=0xA5A5 with sram_addr=0x01234 stable through DONE. A subsequent read of 0x1234 returns 0xA5A5; rdata is unchanged by the write itself.
- Back-to-back: write 0x0001→0x0010, then in the cycle after DONE a read of 0x0010 → second done exactly 3 cycles after its req; rdata=0x0001; no dropped or duplicated access.
- Reset mid-access: assert rst on the second ACCESS cycle of a write → next edge we_n=1, dq hi-Z, busy=0, no done pulse, rdata=0.
- WAIT_CYCLES=1 build: a read completes with busy high 2 cycles and done at t+2.
- With SRAM_MEM_CTRL_STATS_EN: 3 reads and 2 writes → rd_count=3, wr_count=2. Preload rd_count to 0xFFFF via force, then one read → stays 0xFFFF.
